// File: rtl/debug_addr_nav_pkg.sv
// Shared codes and helpers for the debug address navigator.
// Page codes, reset address and the direction-FSM state encoding live here.
package debug_addr_nav_pkg;

   localparam logic [1:0] PAGE_REGS = 2'b00;
   localparam logic [1:0] PAGE_DP   = 2'b01;
   localparam logic [1:0] PAGE_CP0  = 2'b10;
   localparam logic [1:0] PAGE_REGX = 2'b11;

   localparam logic [7:0] ADDR_RST  = 8'h20;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_DELAY  = 2'b01,
      ST_REPEAT = 2'b10
   } dir_state_t;

   // Index arithmetic wraps naturally in 5 bits (31 -> 0, 0 -> 31).
   function automatic logic [4:0] step_index(input logic [4:0] index, input logic up);
      return up ? index + 5'd1 : index - 5'd1;
   endfunction

   // Page order is a plain 2-bit increment: REGS -> DP -> CP0 -> REGX -> REGS.
   function automatic logic [1:0] next_page(input logic [1:0] page);
      return page + 2'd1;
   endfunction

endpackage

// File: rtl/debug_addr_nav_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, debounced level
// and a registered one-cycle press pulse on the level's rising edge.
module btn_debounce #(
   parameter int DEB_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEB_CYCLES - 1);

   logic             sync_a;
   logic             sync_b;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
      end
   end

   // cnt holds the number of consecutive differing samples already seen;
   // the sample that would make it DEB_CYCLES flips the level instead.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
      end else begin
         press <= 1'b0;
         if (sync_b == level) begin
            cnt <= '0;
         end else if (cnt == CNT_TC) begin
            cnt   <= '0;
            level <= sync_b;
            press <= sync_b;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/debug_addr_nav.sv
// Button-driven page/index debug address navigator for the LCD and debug mux.
// Optional auto-repeat on held up/down buttons is enabled by DEBUG_AUTOREPEAT_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for an up/down press
// ST_DELAY  | active button held, counting down the initial repeat delay
// ST_REPEAT | active button held, stepping every REPEAT_RATE cycles
module debug_addr_nav
   import debug_addr_nav_pkg::*;
#(
   parameter int DEB_CYCLES   = 500000,
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE  = 5000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_page,
   output logic [7:0] addr,
   output logic       addr_chg
);

   logic       lvl_up;
   logic       lvl_down;
   logic       lvl_page;
   logic       press_up;
   logic       press_down;
   logic       press_page;
   logic [1:0] page;
   logic [4:0] index;
   logic       dir_press;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_up),
      .level (lvl_up),
      .press (press_up)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_down),
      .level (lvl_down),
      .press (press_down)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_page (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_page),
      .level (lvl_page),
      .press (press_page)
   );

   // A lone direction press; page wins over it and up+down cancels out.
   assign dir_press = (press_up ^ press_down) & ~press_page;

   assign addr = {1'b0, page, index};

`ifdef DEBUG_AUTOREPEAT_EN

   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
   localparam logic [RPT_W-1:0] DELAY_LD = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RATE_LD  = RPT_W'(REPEAT_RATE - 1);

   dir_state_t       state;
   logic [RPT_W-1:0] rpt_cnt;
   logic             dir_up;
   logic             held;
   logic             unused_lvl;

   assign held       = dir_up ? lvl_up : lvl_down;
   assign unused_lvl = lvl_page;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         page     <= ADDR_RST[6:5];
         index    <= ADDR_RST[4:0];
         addr_chg <= 1'b0;
         state    <= ST_IDLE;
         rpt_cnt  <= '0;
         dir_up   <= 1'b0;
      end else begin
         addr_chg <= 1'b0;
         if (press_page) begin
            page     <= next_page(page);
            addr_chg <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (dir_press) begin
                  index    <= step_index(index, press_up);
                  addr_chg <= 1'b1;
                  dir_up   <= press_up;
                  rpt_cnt  <= DELAY_LD;
                  state    <= ST_DELAY;
               end
            end
            ST_DELAY, ST_REPEAT: begin
               if (!held) begin
                  rpt_cnt <= '0;
                  state   <= ST_IDLE;
               end else if (rpt_cnt == '0) begin
                  // A coincident page press owns this cycle's change.
                  if (!press_page) begin
                     index    <= step_index(index, dir_up);
                     addr_chg <= 1'b1;
                  end
                  rpt_cnt <= RATE_LD;
                  state   <= ST_REPEAT;
               end else begin
                  rpt_cnt <= rpt_cnt - 1'b1;
               end
            end
            default: begin
               rpt_cnt <= '0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

`else

   logic unused_lvl;

   assign unused_lvl = ^{lvl_up, lvl_down, lvl_page};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         page     <= ADDR_RST[6:5];
         index    <= ADDR_RST[4:0];
         addr_chg <= 1'b0;
      end else begin
         addr_chg <= 1'b0;
         if (press_page) begin
            page     <= next_page(page);
            addr_chg <= 1'b1;
         end else if (dir_press) begin
            index    <= step_index(index, press_up);
            addr_chg <= 1'b1;
         end
      end
   end

`endif

endmodule
